// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage.
//   - funct3 access-size encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU)
//   - FSM state type lsu_state_t {IDLE, REQ, WAIT}
//   - helpers for forcing alignment and detecting misaligned accesses
package common;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    // Clear the low address bits that a halfword/word access cannot use.
    // Unknown size codes are handled as word accesses.
    function automatic logic [31:0] force_align(input logic [31:0] addr, input logic [2:0] f3);
        case (f3)
            LS_B, LS_BU: return addr;
            LS_H, LS_HU: return {addr[31:1], 1'b0};
            default:     return {addr[31:2], 2'b00};
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lo, input logic [2:0] f3);
        case (f3)
            LS_B, LS_BU: return 1'b0;
            LS_H, LS_HU: return lo[0];
            default:     return |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_stage_align.sv
// lsu_align: combinational byte-lane steering for the load/store stage.
//   addr_lo_i    : byte offset within the word
//   funct3_i     : access size / signedness
//   store_data_i : raw store operand
//   rdata_i      : raw word returned by data memory
//   be_o         : byte enables for the access
//   wdata_o      : store data replicated across lanes
//   ldata_o      : extracted, sign/zero-extended load value
module lsu_align
    import common::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_h = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        ldata_o = rdata_i;
        case (funct3_i)
            LS_B, LS_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
                ldata_o = {{24{(funct3_i == LS_B) & lane_b[7]}}, lane_b};
            end
            LS_H, LS_HU: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{store_data_i[15:0]}};
                ldata_o = {{16{(funct3_i == LS_H) & lane_h[15]}}, lane_h};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit pipeline stage between execute and writeback.
// Ports:
//   clk, reset_n (async, active-low)
//   ex_valid/ex_ready, alu_result, store_data, mem_read, mem_write,
//   funct3, rd, reg_write                          : from execute
//   dmem_req/we/addr/be/wdata, dmem_gnt,
//   dmem_rvalid, dmem_rdata                        : data memory port
//   wb_valid, wb_data, wb_rd, wb_reg_write,
//   misalign_exc                                   : registered writeback
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of silently aligning them.
module lsu_stage
    import common::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign_exc
);

    lsu_state_t  state_q;
    logic [31:0] addr_q, sdata_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        we_q, rw_q;

    logic        wb_valid_q, wb_rw_q, exc_q;
    logic [31:0] wb_data_q;
    logic [4:0]  wb_rd_q;

    logic        is_mem, is_store, in_misal, issue;
    logic [31:0] in_addr, cur_addr, cur_sdata, ldata;
    logic [2:0]  cur_f3;

    // Both mem_read and mem_write high counts as a load.
    assign is_mem   = mem_read | mem_write;
    assign is_store = mem_write & ~mem_read;
    assign in_addr  = force_align(alu_result, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign in_misal = is_mem & is_misaligned(alu_result[1:0], funct3);
`else
    assign in_misal = 1'b0;
`endif

    assign ex_ready = (state_q == IDLE);
    assign issue    = ex_ready & ex_valid & is_mem & ~in_misal;

    // In IDLE the request is driven straight from execute so it can be
    // granted in the acceptance cycle; afterwards the latched copy holds it.
    assign cur_addr  = ex_ready ? in_addr    : addr_q;
    assign cur_sdata = ex_ready ? store_data : sdata_q;
    assign cur_f3    = ex_ready ? funct3     : f3_q;

    assign dmem_req  = issue | (state_q == REQ);
    assign dmem_we   = ex_ready ? is_store : we_q;
    assign dmem_addr = {cur_addr[31:2], 2'b00};

    lsu_align u_align (
        .addr_lo_i    (cur_addr[1:0]),
        .funct3_i     (cur_f3),
        .store_data_i (cur_sdata),
        .rdata_i      (dmem_rdata),
        .be_o         (dmem_be),
        .wdata_o      (dmem_wdata),
        .ldata_o      (ldata)
    );

    always_ff @(posedge clk) begin
        if (ex_ready && ex_valid && is_mem) begin
            addr_q  <= in_addr;
            sdata_q <= store_data;
            f3_q    <= funct3;
            rd_q    <= rd;
            we_q    <= is_store;
            rw_q    <= reg_write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            exc_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= alu_result;
                            wb_rd_q    <= rd;
                            wb_rw_q    <= reg_write;
                        end else if (in_misal) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= alu_result;
                            wb_rd_q    <= rd;
                            wb_rw_q    <= 1'b0;
                            exc_q      <= 1'b1;
                        end else if (dmem_gnt) begin
                            if (is_store) begin
                                wb_valid_q <= 1'b1;
                                wb_rd_q    <= rd;
                                wb_rw_q    <= 1'b0;
                            end else begin
                                state_q <= WAIT;
                            end
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        if (we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_rw_q    <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= ldata;
                        wb_rd_q    <= rd_q;
                        wb_rw_q    <= rw_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign misalign_exc = exc_q;

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;
    import common::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic        wb_valid, wb_reg_write, misalign_exc;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .rd(rd), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .misalign_exc(misalign_exc)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        rw;
        logic        exc;
    } wb_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    wb_t  exp_wb[$];
    req_t exp_req[$];

    logic [7:0]  model_mem [0:63];   // reference model: byte-addressed memory
    logic [31:0] resp_mem  [0:15];   // memory behind the responder, written via DUT lanes

    int n_total = 0, n_pass = 0;

    // responder controls
    int   gnt_fix = 0, rv_fix = -1;
    bit   spur_en = 1'b0;
    int   rv_cnt = 0, req_age = 0;
    logic [3:0] rv_word = '0;

    // monitor statistics
    int   req_cycles = 0, wb_pulses = 0, exc_pulses = 0, cyc = 0;
    int   last_gnt_cyc = 0, last_wb_cyc = 0;
    logic [31:0] last_req_addr = '0, last_wb_data = '0;

    logic [2:0] f3_tab [0:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: event did not match the expected behaviour", name);
    endtask

    // Reference model: computes what an accepted instruction must produce.
    function automatic void model_accept(input logic [31:0] a, input logic [31:0] sd,
                                         input logic mr, input logic mw, input logic [2:0] f3,
                                         input logic [4:0] r, input logic rw);
        wb_t w;
        req_t q;
        int nb, base;
        logic [31:0] ea, v;
        w = '0;
        q = '0;
        w.rd = r;
        if (!mr && !mw) begin
            w.data = a; w.chk_data = 1'b1; w.rw = rw;
            exp_wb.push_back(w);
            return;
        end
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((int'(a[1:0]) % nb) != 0) begin
            w.exc = 1'b1;
            exp_wb.push_back(w);
            return;
        end
`endif
        ea = a & ~(32'(nb) - 32'd1);
        q.addr = ea & ~32'd3;
        q.we = mw && !mr;
        for (int k = 0; k < 4; k++) q.wdata[8*k +: 8] = sd[8*(k % nb) +: 8];
        for (int i = 0; i < nb; i++) q.be[int'(ea[1:0]) + i] = 1'b1;
        base = int'(ea[5:0]);
        if (q.we) begin
            for (int i = 0; i < nb; i++) model_mem[base + i] = sd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(model_mem[base + i]) << (8*i));
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            w.data = v; w.chk_data = 1'b1; w.rw = rw;
        end
        exp_req.push_back(q);
        exp_wb.push_back(w);
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        resp_mem[a[5:2]] = v;
        for (int i = 0; i < 4; i++) model_mem[int'({a[5:2], 2'b00}) + i] = v[8*i +: 8];
    endtask

    // Drive one instruction until accepted; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic mr,
                         input logic mw, input logic [2:0] f3, input logic [4:0] r, input logic rw);
        bit acc;
        acc = 1'b0;
        ex_valid = 1'b1; alu_result = a; store_data = sd;
        mem_read = mr; mem_write = mw; funct3 = f3; rd = r; reg_write = rw;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ex_ready) begin
                model_accept(a, sd, mr, mw, f3, r, rw);
                acc = 1'b1;
                break;
            end
        end
        if (!acc) fail_now("accept_timeout");
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #2;
            if (ex_ready && exp_wb.size() == 0 && exp_req.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now("quiet_timeout");
        @(posedge clk); #1;
    endtask

    // Memory responder
    initial begin
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = resp_mem[rv_word];
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                dmem_rvalid = 1'b1;
            end
            dmem_gnt = 1'b0;
            if (reset_n && dmem_req) begin
                if (gnt_fix >= 0) dmem_gnt = (req_age == gnt_fix);
                else dmem_gnt = ($urandom_range(0, 2) != 0);
                req_age++;
                if (dmem_gnt) begin
                    req_age = 0;
                    if (dmem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (dmem_be[k]) resp_mem[dmem_addr[5:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
                    end else begin
                        rv_word = dmem_addr[5:2];
                        rv_cnt  = (rv_fix > 0) ? rv_fix : int'($urandom_range(1, 4));
                    end
                end
            end else begin
                req_age = 0;
                if (spur_en && $urandom_range(0, 7) == 0) dmem_gnt = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        wb_t  e;
        req_t q;
        bit   hold_pend;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_be;
        hold_pend = 1'b0;
        p_addr = '0; p_wdata = '0; p_be = '0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (wb_valid) begin
                    wb_pulses++;
                    last_wb_cyc  = cyc;
                    last_wb_data = wb_data;
                    if (misalign_exc) exc_pulses++;
                    if (exp_wb.size() == 0) fail_now("wb_unexpected");
                    else begin
                        e = exp_wb.pop_front();
                        check("wb_rd", 32'(wb_rd), 32'(e.rd));
                        check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                        check("misalign_exc", 32'(misalign_exc), 32'(e.exc));
                        if (e.chk_data) check("wb_data", wb_data, e.data);
                    end
                end else if (misalign_exc) begin
                    fail_now("exc_without_wb");
                end
                if (dmem_req) begin
                    req_cycles++;
                    if (hold_pend) begin
                        check("req_hold_addr", dmem_addr, p_addr);
                        check("req_hold_wdata", dmem_wdata, p_wdata);
                        check("req_hold_be", 32'(dmem_be), 32'(p_be));
                    end
                    if (dmem_gnt) begin
                        hold_pend = 1'b0;
                        last_req_addr = dmem_addr;
                        last_gnt_cyc  = cyc;
                        if (exp_req.size() == 0) fail_now("req_unexpected");
                        else begin
                            q = exp_req.pop_front();
                            check("dmem_addr", dmem_addr, q.addr);
                            check("dmem_we", 32'(dmem_we), 32'(q.we));
                            check("dmem_be", 32'(dmem_be), 32'(q.be));
                            if (q.we) check("dmem_wdata", dmem_wdata, q.wdata);
                        end
                    end else begin
                        hold_pend = 1'b1;
                        p_addr = dmem_addr; p_wdata = dmem_wdata; p_be = dmem_be;
                    end
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int lowc, bad;
        logic [2:0] f3r;
        int kind;
        f3_tab[0] = LS_B; f3_tab[1] = LS_H; f3_tab[2] = LS_W; f3_tab[3] = LS_BU; f3_tab[4] = LS_HU;
        reset_n = 1'b0; ex_valid = 1'b0; alu_result = '0; store_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; rd = '0; reg_write = 1'b0;
        for (int i = 0; i < 16; i++) set_word(32'(i) << 2, $urandom);

        // reset state
        @(negedge clk);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        check("rst_misalign_exc", 32'(misalign_exc), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("ex_ready_after_release", 32'(ex_ready), 32'd1);
        @(posedge clk); #1;

        // ALU passthrough
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        wait_quiet();
        check("alu_wb_data", last_wb_data, 32'h1234);

        // SB with grant delayed two cycles
        gnt_fix = 2; req_cycles = 0; wb_pulses = 0;
        issue(32'h103, 32'hAB, 1'b0, 1'b1, LS_B, 5'd7, 1'b1);
        wait_quiet();
        check("sb_req_cycles", 32'(req_cycles), 32'd3);
        check("sb_addr", last_req_addr, 32'h100);
        check("sb_wb_pulses", 32'(wb_pulses), 32'd1);
        check("sb_wb_after_gnt", 32'(last_wb_cyc - last_gnt_cyc), 32'd1);
        gnt_fix = 0;

        // load extraction
        set_word(32'h200, 32'h0080_0000);
        issue(32'h202, 32'h0, 1'b1, 1'b0, LS_B, 5'd1, 1'b1);
        wait_quiet();
        check("lb_sext", last_wb_data, 32'hFFFF_FF80);
        issue(32'h202, 32'h0, 1'b1, 1'b0, LS_BU, 5'd2, 1'b1);
        wait_quiet();
        check("lbu_zext", last_wb_data, 32'h0000_0080);
        set_word(32'h200, 32'h8000_0000);
        issue(32'h202, 32'h0, 1'b1, 1'b0, LS_HU, 5'd3, 1'b1);
        wait_quiet();
        check("lhu_zext", last_wb_data, 32'h0000_8000);
        issue(32'h202, 32'h0, 1'b1, 1'b0, LS_H, 5'd4, 1'b1);
        wait_quiet();
        check("lh_sext", last_wb_data, 32'hFFFF_8000);

        // LW with rvalid four cycles after grant
        rv_fix = 4; req_cycles = 0; wb_pulses = 0; lowc = 0; bad = 0;
        issue(32'h44, 32'h0, 1'b1, 1'b0, LS_W, 5'd6, 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #2;
            if (wb_pulses > 0) break;
            if (ex_ready) bad++;
            else lowc++;
        end
        check("lw_ready_high_in_wait", 32'(bad), 32'd0);
        check("lw_wait_cycles", 32'(lowc), 32'd4);
        idle(5);
        check("lw_wb_pulses", 32'(wb_pulses), 32'd1);
        check("lw_req_cycles", 32'(req_cycles), 32'd1);
        rv_fix = -1;

        // misaligned word access
        req_cycles = 0; exc_pulses = 0;
        issue(32'h101, 32'h0, 1'b1, 1'b0, LS_W, 5'd8, 1'b1);
        wait_quiet();
        idle(2);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_no_req", 32'(req_cycles), 32'd0);
        check("mis_exc_pulses", 32'(exc_pulses), 32'd1);
`else
        check("mis_aligned_addr", last_req_addr, 32'h100);
        check("mis_exc_pulses", 32'(exc_pulses), 32'd0);
`endif

        // reset while waiting for load data, response arrives late
        rv_fix = 6; wb_pulses = 0;
        issue(32'h80, 32'h0, 1'b1, 1'b0, LS_W, 5'd9, 1'b1);
        idle(2);
        #3 reset_n = 1'b0;
        #1;
        check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mid_ex_ready", 32'(ex_ready), 32'd1);
        exp_wb.delete();
        exp_req.delete();
        idle(2);
        reset_n = 1'b1;
        idle(8);
        check("rst_late_rvalid_wb", 32'(wb_pulses), 32'd0);
        check("rst_late_ex_ready", 32'(ex_ready), 32'd1);
        rv_fix = -1;

        // randomized traffic with random grant/response timing and stray handshakes
        gnt_fix = -1; spur_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 6));
            f3r  = f3_tab[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            case (kind)
                0, 1: issue($urandom, $urandom, 1'b0, 1'b0, f3r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                2, 3: issue($urandom, $urandom, 1'b1, 1'b0, f3r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                4, 5: issue($urandom, $urandom, 1'b0, 1'b1, f3_tab[$urandom_range(0, 2)], 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
                default: issue($urandom, $urandom, 1'b1, 1'b1, f3r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            endcase
        end
        wait_quiet();
        spur_en = 1'b0;
        idle(10);
        check("final_wb_queue", 32'(exp_wb.size()), 32'd0);
        check("final_req_queue", 32'(exp_req.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
